// File: rtl/strobe_monitor.sv
// rtl/strobe_monitor.sv - periodic strobe interval checker with lock detect and error count
module strobe_monitor #(
    parameter int CLOCK_HZ     = 10_000_000,
    parameter int PERIOD_NS    = 100_000,
    parameter int TOLERANCE_NS = 1_000,
    parameter int LOCK_COUNT   = 4,
    localparam longint NOMINAL_L = (longint'(CLOCK_HZ) * longint'(PERIOD_NS)) / 64'sd1_000_000_000,
    localparam longint TOL_L     = (longint'(CLOCK_HZ) * longint'(TOLERANCE_NS)) / 64'sd1_000_000_000,
    localparam int NOMINAL = int'(NOMINAL_L),
    localparam int TOL     = int'(TOL_L),
    localparam int MIN     = NOMINAL - TOL,
    localparam int MAX     = NOMINAL + TOL,
    localparam int W       = $clog2(MAX + 2)
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Enable_i,
    input  logic         Clear_i,
    input  logic         Strobe_i,
    output logic [W-1:0] Period_o,
    output logic         Valid_o,
    output logic         Early_o,
    output logic         Late_o,
    output logic         Locked_o,
    output logic [7:0]   ErrorCount_o
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [W-1:0]  MIN_C  = W'(MIN);
    localparam logic [W-1:0]  MAX_C  = W'(MAX);
    localparam logic [GW-1:0] LOCK_C = GW'(LOCK_COUNT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;

    if (NOMINAL < 2 || TOL >= NOMINAL || LOCK_COUNT < 1) begin : g_param_check
        $fatal(1, "strobe_monitor: invalid timing parameters");
    end

    logic [1:0]    state;
    logic [W-1:0]  counter;
    logic [GW-1:0] good_count;
    logic [GW-1:0] good_next;
    logic          is_early;
    logic          is_late;
    logic          err_event;

    // A strobe on the MAX cycle is a valid interval, so late requires no strobe.
    always_comb begin
        is_early  = 1'b0;
        is_late   = 1'b0;
        err_event = 1'b0;
        good_next = good_count;
        if (state == S_MEASURE) begin
            is_early = Strobe_i && (counter < MIN_C);
            is_late  = !Strobe_i && (counter == MAX_C);
        end
        err_event = Enable_i && (is_early || is_late);
        if (good_count < LOCK_C) begin
            good_next = good_count + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= S_IDLE;
            counter      <= '0;
            good_count   <= '0;
            Period_o     <= '0;
            Valid_o      <= 1'b0;
            Early_o      <= 1'b0;
            Late_o       <= 1'b0;
            Locked_o     <= 1'b0;
            ErrorCount_o <= 8'd0;
        end else begin
            Valid_o <= 1'b0;
            Early_o <= 1'b0;
            Late_o  <= 1'b0;

            if (Clear_i) begin
                ErrorCount_o <= 8'd0;
            end else if (err_event && ErrorCount_o != 8'hFF) begin
                ErrorCount_o <= ErrorCount_o + 8'd1;
            end

            if (!Enable_i) begin
                state      <= S_IDLE;
                counter    <= '0;
                good_count <= '0;
                Locked_o   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: state <= S_WAIT;
                    S_WAIT: begin
                        if (Strobe_i) begin
                            counter <= W'(1);
                            state   <= S_MEASURE;
                        end
                    end
                    S_MEASURE: begin
                        if (Strobe_i) begin
                            Period_o <= counter;
                            Valid_o  <= 1'b1;
                            counter  <= W'(1);
                            if (is_early) begin
                                Early_o    <= 1'b1;
                                good_count <= '0;
                                Locked_o   <= 1'b0;
                            end else begin
                                good_count <= good_next;
                                Locked_o   <= (good_next == LOCK_C);
                            end
                        end else if (is_late) begin
                            Late_o     <= 1'b1;
                            good_count <= '0;
                            Locked_o   <= 1'b0;
                            counter    <= '0;
                            state      <= S_WAIT;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_strobe_monitor.sv
// tb/tb_strobe_monitor.sv - scoreboard bench for strobe_monitor
module tb_strobe_monitor;

    localparam int W      = 10;
    localparam int MIN    = 990;
    localparam int MAX    = 1010;
    localparam int LOCKN  = 4;
    localparam int M_IDLE = 0, M_WAIT = 1, M_MEAS = 2;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         Enable_i = 1'b0;
    logic         Clear_i = 1'b0;
    logic         Strobe_i = 1'b0;
    logic [W-1:0] Period_o;
    logic         Valid_o, Early_o, Late_o, Locked_o;
    logic [7:0]   ErrorCount_o;

    strobe_monitor dut (
        .Clock(Clock), .Reset(Reset), .Enable_i(Enable_i), .Clear_i(Clear_i),
        .Strobe_i(Strobe_i), .Period_o(Period_o), .Valid_o(Valid_o),
        .Early_o(Early_o), .Late_o(Late_o), .Locked_o(Locked_o),
        .ErrorCount_o(ErrorCount_o)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic v, e, l, lk;
        int   per;
        int   err;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    int m_state = M_IDLE, m_good = 0, m_err = 0, m_period = 0, m_last = 0;
    logic m_locked = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic model_strobe(input int n, input logic clr);
        exp_t r;
        logic early;
        if (m_state == M_MEAS) begin
            early = (n < MIN);
            if (early) begin
                m_good = 0;
                m_locked = 1'b0;
            end else begin
                if (m_good < LOCKN) m_good++;
                m_locked = (m_good == LOCKN);
            end
            if (clr) m_err = 0;
            else if (early && m_err < 255) m_err++;
            m_period = n;
            r = '{cyc: cyc + 1, v: 1'b1, e: early, l: 1'b0, lk: m_locked, per: n, err: m_err};
            sb.push_back(r);
        end else if (m_state == M_WAIT) begin
            m_state = M_MEAS;
            if (clr) m_err = 0;
        end
        m_last = cyc + 1;
    endtask

    task automatic pulse_after(input int n, input logic clr = 1'b0);
        repeat (n - 1) @(posedge Clock);
        #1;
        Strobe_i = 1'b1;
        Clear_i  = clr;
        model_strobe(n, clr);
        @(posedge Clock);
        #1;
        Strobe_i = 1'b0;
        Clear_i  = 1'b0;
    endtask

    task automatic expect_late();
        exp_t r;
        if (m_err < 255) m_err++;
        m_good = 0;
        m_locked = 1'b0;
        m_state = M_WAIT;
        r = '{cyc: m_last + MAX, v: 1'b0, e: 1'b0, l: 1'b1, lk: 1'b0, per: m_period, err: m_err};
        sb.push_back(r);
        repeat (MAX + 5) @(posedge Clock);
        #1;
    endtask

    // Every output pulse must match the next expected event, field by field.
    always @(negedge Clock) begin
        exp_t r;
        if (Reset && (Valid_o || Early_o || Late_o)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {29'd0, Valid_o, Early_o, Late_o}, 32'd0);
            end else begin
                r = sb.pop_front();
                check("pulse_cycle", cyc, r.cyc);
                check("valid", Valid_o, r.v);
                check("early", Early_o, r.e);
                check("late", Late_o, r.l);
                check("locked", Locked_o, r.lk);
                check("period", Period_o, r.per);
                check("err_count", ErrorCount_o, r.err);
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_period", Period_o, 0);
        check("rst_pulses", {Valid_o, Early_o, Late_o, Locked_o}, 0);
        check("rst_err", ErrorCount_o, 0);
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock);
        #1 Enable_i = 1'b1;
        m_state = M_WAIT;

        // Nominal train: five valid intervals, lock on the fourth
        pulse_after(3);
        repeat (5) pulse_after(1000);

        // Early just below MIN, then MIN itself is accepted
        pulse_after(989);
        pulse_after(990);
        repeat (3) pulse_after(1000);
        pulse_after(1010);

        // Timeout, then the restart strobe gives no Valid_o
        expect_late();
        pulse_after(7);

        // Saturate the error counter, then clear on the same edge as an early event
        repeat (260) pulse_after(2);
        pulse_after(2, 1'b1);
        @(negedge Clock);
        check("err_after_clear", ErrorCount_o, 0);

        // Disable mid-interval while locked, strobe in the same cycle
        repeat (4) pulse_after(1000);
        repeat (500) @(posedge Clock);
        #1;
        Enable_i = 1'b0;
        Strobe_i = 1'b1;
        m_state = M_IDLE;
        m_good = 0;
        m_locked = 1'b0;
        @(posedge Clock);
        #1 Strobe_i = 1'b0;
        @(negedge Clock);
        check("dis_locked", Locked_o, 0);
        check("dis_period", Period_o, 1000);
        repeat (3) @(posedge Clock);
        #1 Enable_i = 1'b1;
        m_state = M_WAIT;
        pulse_after(5);
        pulse_after(1000);

        // Asynchronous reset between edges with Counter = 500
        repeat (499) @(posedge Clock);
        check("sb_drained_pre_reset", sb.size(), 0);
        #3 Reset = 1'b0;
        #1;
        check("arst_period", Period_o, 0);
        check("arst_pulses", {Valid_o, Early_o, Late_o, Locked_o}, 0);
        check("arst_err", ErrorCount_o, 0);
        m_state = M_WAIT;
        m_good = 0;
        m_locked = 1'b0;
        m_err = 0;
        m_period = 0;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b1;
        pulse_after(5);
        pulse_after(1000);

        repeat (5) @(posedge Clock);
        check("sb_drained_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
